// File: rtl/sipo_i2s_rx.sv
// I2S receive deserializer: shifts in MSB-first serial data on each bit strobe
// and commits left/right words on word-select edges, one bit after the edge.
//
// state | meaning
// SYNC  | after reset; capture runs, the first word-select edge is discarded
// RUN   | aligned; every word-select edge commits the outgoing channel word
module sipo_i2s_rx #(
  parameter int WD = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          ws_i,
  input  logic          sdata_i,
  output logic [WD-1:0] left_o,
  output logic [WD-1:0] right_o,
  output logic          valid_o,
  output logic          short_o
);

  localparam int CW = $clog2(WD + 1);
  localparam logic [CW-1:0] WD_C = CW'(WD);

  typedef enum logic {SYNC, RUN} state_t;

  state_t        state_q;
  logic [WD-1:0] shreg_q;
  logic [WD-1:0] word;
  logic [CW-1:0] cnt_q;
  logic          ws_prev_q;
  logic          left_seen_q;
  logic          ws_edge;
  logic          short_w;

  // Word as it stands after capturing this strobe's bit; a saturated count drops the bit.
  always_comb begin
    word = shreg_q;
    for (int i = 0; i < WD; i++) begin
      if (cnt_q == CW'(WD - 1 - i)) word[i] = sdata_i;
    end
  end

  assign ws_edge = (ws_i != ws_prev_q);
  assign short_w = (cnt_q < (WD_C - CW'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SYNC;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ws_prev_q   <= 1'b0;
      left_seen_q <= 1'b0;
      left_o      <= '0;
      right_o     <= '0;
      valid_o     <= 1'b0;
      short_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      short_o <= 1'b0;
      if (en_i) begin
        ws_prev_q <= ws_i;
        if (ws_edge) begin
          shreg_q <= '0;
          cnt_q   <= '0;
          if (state_q == SYNC) begin
            state_q <= RUN;
          end else begin
            if (!ws_prev_q) begin
              left_o      <= word;
              left_seen_q <= 1'b1;
            end else begin
              right_o <= word;
              if (left_seen_q) begin
                valid_o     <= 1'b1;
                left_seen_q <= 1'b0;
              end
            end
            short_o <= short_w;
          end
        end else begin
          shreg_q <= word;
          if (cnt_q != WD_C) cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo_i2s_rx.sv
// Scoreboard bench for sipo_i2s_rx: expected left/right pairs are queued as
// frames are driven and popped when valid_o fires.
module tb_sipo_i2s_rx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        ws_i = 1'b0;
  logic        sdata_i = 1'b0;
  logic [15:0] left_o;
  logic [15:0] right_o;
  logic        valid_o;
  logic        short_o;

  int checks = 0;
  int errors = 0;
  int short_cnt = 0;
  int gap = 1;
  bit noise = 0;
  logic [31:0] exp_q[$];

  sipo_i2s_rx #(.WD(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .ws_i(ws_i), .sdata_i(sdata_i),
    .left_o(left_o), .right_o(right_o), .valid_o(valid_o), .short_o(short_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued pair.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (valid_o) begin
          if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
          else chk("valid_pair", {left_o, right_o}, exp_q.pop_front());
        end
        if (short_o) short_cnt++;
      end
    end
  end

  task automatic strobe(input logic ws, input logic sd);
    en_i = 1'b1; ws_i = ws; sdata_i = sd;
    @(posedge clk_i); #1;
    en_i = 1'b0;
    for (int k = 1; k < gap; k++) begin
      if (noise) begin
        ws_i = 1'($urandom); sdata_i = 1'($urandom);
      end
      @(posedge clk_i); #1;
    end
  endtask

  // One channel slot of nbits; the last bit already carries the next slot's ws.
  task automatic slot(input logic ws, input logic [31:0] data, input int nbits, input logic next_ws);
    for (int j = 0; j < nbits; j++)
      strobe((j == nbits - 1) ? next_ws : ws, data[nbits-1-j]);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    short_cnt = 0;
    exp_q.delete();
    chk("reset_lr", {left_o, right_o}, 32'h0);
    chk("reset_pulses", {30'd0, valid_o, short_o}, 32'h0);
  endtask

  task automatic sync_frames();
    slot(1'b0, 32'h0000_7E7E, 16, 1'b1);
    slot(1'b1, 32'h0000_C001, 16, 1'b0);
    chk("sync_right", {left_o, right_o}, {16'h0000, 16'hC001});
  endtask

  task automatic finish_scn(input string tag, input int exp_short);
    repeat (3) @(posedge clk_i);
    #1;
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_short"}, short_cnt, exp_short);
  endtask

  task automatic std_frame();
    sync_frames();
    exp_q.push_back({16'hA5C3, 16'h1234});
    slot(1'b0, 32'h0000_A5C3, 16, 1'b1);
    slot(1'b1, 32'h0000_1234, 16, 1'b0);
  endtask

  initial begin
    // Scenario 1: no ws edge, stays in SYNC
    do_reset();
    for (int i = 0; i < 40; i++) begin
      strobe(1'b0, 1'($urandom));
      chk("sync_hold", {left_o, right_o}, 32'h0);
    end
    finish_scn("s1", 0);

    // Scenario 2: standard 16-bit frame
    do_reset();
    std_frame();
    finish_scn("s2", 0);
    chk("s2_lr", {left_o, right_o}, {16'hA5C3, 16'h1234});

    // Scenario 3: 32-bit slots, extra bits dropped
    do_reset();
    sync_frames();
    exp_q.push_back({16'hBEEF, 16'h0F0F});
    slot(1'b0, 32'hBEEF_FFFF, 32, 1'b1);
    slot(1'b1, 32'h0F0F_0000, 32, 1'b0);
    finish_scn("s3", 0);

    // Scenario 4: short left word is left-aligned
    do_reset();
    sync_frames();
    slot(1'b0, 32'h0000_0ABC, 12, 1'b1);
    @(negedge clk_i);
    chk("s4_left", {16'h0, left_o}, 32'h0000_ABC0);
    exp_q.push_back({16'hABC0, 16'h5555});
    slot(1'b1, 32'h0000_5555, 16, 1'b0);
    finish_scn("s4", 1);

    // Scenario 5: sparse strobes with noise between them
    do_reset();
    gap = 4; noise = 1;
    std_frame();
    finish_scn("s5", 0);
    gap = 1; noise = 0;

    // Scenario 6: reset in the middle of a left word
    do_reset();
    sync_frames();
    exp_q.push_back({16'h1111, 16'h2222});
    slot(1'b0, 32'h0000_1111, 16, 1'b1);
    slot(1'b1, 32'h0000_2222, 16, 1'b0);
    repeat (2) @(posedge clk_i);
    for (int j = 0; j < 7; j++) strobe(1'b0, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("midreset_lr", {left_o, right_o}, 32'h0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    chk("postreset_pulses", {30'd0, valid_o, short_o}, 32'h0);
    chk("s6a_drained", exp_q.size(), 0);
    short_cnt = 0;
    slot(1'b0, 32'h0000_3333, 16, 1'b1);
    @(negedge clk_i);
    chk("s6_discard", {left_o, right_o}, 32'h0);
    slot(1'b1, 32'h0000_4444, 16, 1'b0);
    exp_q.push_back({16'h0001, 16'h8000});
    slot(1'b0, 32'h0000_0001, 16, 1'b1);
    slot(1'b1, 32'h0000_8000, 16, 1'b0);
    finish_scn("s6", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
